// File: rtl/exec_sequencer.sv
// exec_sequencer
// Multi-cycle instruction sequencer for the 8-bit execute stage. It fetches
// 16-bit instruction words, holds them in the instruction register (IR), and
// splits them into execute-stage control fields. It also gates the execute
// enable, issues register/memory write strobes, latches the ALU flags and
// resolves jump/branch/halt by owning the 6-bit PC.
//
// Build option:
//   EXEC_SEQ_SINGLE_STEP_EN - adds a 'step' input and a PAUSE state that is
//                             entered after every writeback. The sequencer
//                             leaves PAUSE on a cycle with step=1.
//
// Instruction cycle: FETCH (waits for instr_valid) -> DECODE -> EXEC (1 cycle,
// or MULDIV_LAT cycles for mul/div) -> WB -> FETCH. Opcode 11111 halts the
// sequencer in DECODE, and only reset leaves HALTED.
//
// Every strobe and status output is a register. Each one is loaded on the
// edge that enters the state it belongs to, so it is glitch-free and reflects
// the current state.

module exec_sequencer #(
    parameter int         MULDIV_LAT = 2,     // EXEC dwell for mul/div, legal range 1..7
    parameter logic [5:0] PC_RESET   = 6'd0   // PC value loaded on reset
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
`ifdef EXEC_SEQ_SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic        instr_req,
    output logic [5:0]  instr_addr,
    input  logic        instr_valid,
    input  logic [15:0] instr_data,
    output logic [4:0]  opcode,
    output logic        am,
    output logic [2:0]  rd,
    output logic [2:0]  rs1,
    output logic [2:0]  rs2,
    output logic [2:0]  s_r_amount,
    output logic [3:0]  mem_addr,
    output logic        exec_enable,
    output logic        reg_we,
    output logic        reg_we_wide,
    output logic        mem_we,
    input  logic        zero_in,
    input  logic        carry_in,
    input  logic        parity_in,
    output logic        z_flag,
    output logic        c_flag,
    output logic        p_flag,
    output logic [5:0]  pc,
    output logic        busy,
    output logic        halted
);

    // ------------------------------------------------------------------
    // Opcodes that the sequencer itself needs to recognise
    // ------------------------------------------------------------------
    localparam logic [4:0] OP_MUL   = 5'b00011;
    localparam logic [4:0] OP_DIV   = 5'b00100;
    localparam logic [4:0] OP_STORE = 5'b01100;
    localparam logic [4:0] OP_JUMP  = 5'b01101;
    localparam logic [4:0] OP_BZ    = 5'b01110;
    localparam logic [4:0] OP_BC    = 5'b10110;
    localparam logic [4:0] OP_BP    = 5'b10111;
    localparam logic [4:0] OP_BNZ   = 5'b11000;
    localparam logic [4:0] OP_CMP   = 5'b11001;
    localparam logic [4:0] OP_HALT  = 5'b11111;

    // Final EXEC count value for mul/div. Only the range 1..7 is legal, so
    // the value always fits the 3-bit dwell counter.
    localparam logic [2:0] MULDIV_LAST = 3'(MULDIV_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_WB      = 3'd4,
        S_HALTED  = 3'd5
`ifdef EXEC_SEQ_SINGLE_STEP_EN
        ,S_PAUSE  = 3'd6
`endif
    } state_t;

    state_t      state;
    logic [15:0] ir;          // instruction register
    logic [2:0]  exec_cnt;    // EXEC dwell counter, cleared on entry to EXEC

    // Decoded properties of the instruction that is held in IR
    logic [4:0]  op;
    logic        is_muldiv;
    logic        upd_zp;      // last EXEC cycle latches z and p
    logic        upd_c;       // last EXEC cycle latches c
    logic        wr_reg;      // WB writes result[7:0] to rd
    logic        wr_mem;      // WB stores to mem_addr
    logic        take_pc;     // WB loads pc from IR[5:0]
    logic        exec_last;   // this is the final EXEC cycle

    // ------------------------------------------------------------------
    // Field outputs come straight from IR. rs2 and s_r_amount share IR[3:1]
    // because the opcode decides which meaning applies.
    // ------------------------------------------------------------------
    assign op         = ir[15:11];
    assign opcode     = ir[15:11];
    assign am         = ir[10];
    assign rd         = ir[9:7];
    assign rs1        = ir[6:4];
    assign rs2        = ir[3:1];
    assign s_r_amount = ir[3:1];
    assign mem_addr   = ir[3:0];
    assign instr_addr = pc;

    // Classify the IR opcode: flag update, write target and PC redirect.
    always_comb begin
        // NOTE: give every always_comb output a value before any branch, so
        // that no path holds a stale value and no latch is inferred.
        is_muldiv = 1'b0;
        upd_zp    = 1'b0;
        upd_c     = 1'b0;
        wr_reg    = 1'b0;
        wr_mem    = 1'b0;
        take_pc   = 1'b0;

        is_muldiv = (op == OP_MUL) || (op == OP_DIV);
        upd_zp    = (op inside {[5'b00001:5'b01010], [5'b10000:5'b10101], OP_CMP});
        upd_c     = (op inside {5'b00001, 5'b00010, 5'b00101, 5'b00110,
                                [5'b10000:5'b10011]});
        wr_reg    = (op inside {[5'b00000:5'b01011], [5'b10000:5'b10101]});
        wr_mem    = (op == OP_STORE);

        // A branch tests the flags as they stand at WB. The flags are
        // already updated by this instruction's EXEC when it updates them.
        case (op)
            OP_JUMP: take_pc = 1'b1;
            OP_BZ:   take_pc = z_flag;
            OP_BC:   take_pc = c_flag;
            OP_BP:   take_pc = p_flag;
            OP_BNZ:  take_pc = !z_flag;
            default: take_pc = 1'b0;
        endcase
    end

    // EXEC lasts one cycle, or MULDIV_LAT cycles for mul/div.
    assign exec_last = is_muldiv ? (exec_cnt == MULDIV_LAST) : (exec_cnt == 3'd0);

    // Sequencer FSM: state, PC, IR, flags and all registered strobes/status.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Synchronous reset from any state. An instruction that is in
            // flight is dropped, and no strobe fires on the following cycle.
            state       <= S_IDLE;
            pc          <= PC_RESET;
            ir          <= 16'h0000;
            exec_cnt    <= 3'd0;
            instr_req   <= 1'b0;
            exec_enable <= 1'b0;
            reg_we      <= 1'b0;
            reg_we_wide <= 1'b0;
            mem_we      <= 1'b0;
            z_flag      <= 1'b0;
            c_flag      <= 1'b0;
            p_flag      <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout. Every register here
            // sees the pre-edge values of the others, whatever the order of
            // the statements below.
            // Strobes are single-state pulses. They drop by default, and the
            // transition into a state re-asserts the strobes that state owns.
            instr_req   <= 1'b0;
            exec_enable <= 1'b0;
            reg_we      <= 1'b0;
            reg_we_wide <= 1'b0;
            mem_we      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_FETCH;
                        instr_req <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                S_FETCH: begin
                    if (instr_valid) begin
                        ir    <= instr_data;
                        pc    <= pc + 6'd1;          // 63 wraps to 0
                        state <= S_DECODE;
                    end else begin
                        instr_req <= 1'b1;           // hold the request
                    end
                end

                S_DECODE: begin
                    if (op == OP_HALT) begin
                        state  <= S_HALTED;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        state       <= S_EXEC;
                        exec_cnt    <= 3'd0;
                        exec_enable <= 1'b1;
                    end
                end

                S_EXEC: begin
                    if (exec_last) begin
                        if (upd_zp) begin
                            z_flag <= zero_in;
                            p_flag <= parity_in;
                        end
                        if (upd_c) begin
                            c_flag <= carry_in;
                        end
                        state       <= S_WB;
                        reg_we      <= wr_reg;
                        reg_we_wide <= is_muldiv;
                        mem_we      <= wr_mem;
                    end else begin
                        exec_cnt    <= exec_cnt + 3'd1;
                        exec_enable <= 1'b1;
                    end
                end

                S_WB: begin
                    if (take_pc) begin
                        pc <= ir[5:0];
                    end
`ifdef EXEC_SEQ_SINGLE_STEP_EN
                    state <= S_PAUSE;
`else
                    state     <= S_FETCH;
                    instr_req <= 1'b1;
`endif
                end

`ifdef EXEC_SEQ_SINGLE_STEP_EN
                S_PAUSE: begin
                    if (step) begin
                        state     <= S_FETCH;
                        instr_req <= 1'b1;
                    end
                end
`endif

                S_HALTED: begin
                    // Only reset leaves HALTED.
                end

                default: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer
// Self-checking bench for exec_sequencer. A transaction-level model turns
// each fetched instruction into a schedule of expected per-cycle outputs and
// end-of-cycle effects. The DUT outputs are compared against the model on
// every falling edge. Directed sequences add literal expectations, and a
// randomized phase then runs random programs, fetch delays, flags and resets.

module tb_exec_sequencer;

    localparam int         LAT = 3;
    localparam logic [5:0] PCR = 6'd0;
`ifdef EXEC_SEQ_SINGLE_STEP_EN
    localparam int         PW  = 1;   // pause cycles after WB when step is held high
`else
    localparam int         PW  = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, instr_valid, zero_in, carry_in, parity_in;
    logic [15:0] instr_data;
`ifdef EXEC_SEQ_SINGLE_STEP_EN
    logic        step;
`endif
    logic        instr_req, exec_enable, reg_we, reg_we_wide, mem_we;
    logic        z_flag, c_flag, p_flag, busy, halted, am;
    logic [5:0]  instr_addr, pc;
    logic [4:0]  opcode;
    logic [2:0]  rd, rs1, rs2, s_r_amount;
    logic [3:0]  mem_addr;

    exec_sequencer #(.MULDIV_LAT(LAT), .PC_RESET(PCR)) dut (
        .clk(clk), .reset(reset), .start(start),
`ifdef EXEC_SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_valid(instr_valid), .instr_data(instr_data),
        .opcode(opcode), .am(am), .rd(rd), .rs1(rs1), .rs2(rs2),
        .s_r_amount(s_r_amount), .mem_addr(mem_addr),
        .exec_enable(exec_enable), .reg_we(reg_we), .reg_we_wide(reg_we_wide),
        .mem_we(mem_we), .zero_in(zero_in), .carry_in(carry_in),
        .parity_in(parity_in), .z_flag(z_flag), .c_flag(c_flag),
        .p_flag(p_flag), .pc(pc), .busy(busy), .halted(halted)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       req, ex, rwe, wide, mwe, busy, halted;
        logic [1:0] act;   // effect applied at the end of this cycle
    } rec_t;
    localparam logic [1:0] A_NONE = 2'd0, A_FLAGS = 2'd1, A_WB = 2'd2, A_HALT = 2'd3;
    typedef enum {M_IDLE, M_RUN, M_HALT} mode_t;

    mode_t       m_mode  = M_IDLE;
    logic        m_pause = 1'b0;
    logic [5:0]  m_pc    = 6'd0;
    logic [15:0] m_ir    = 16'h0000;
    logic        m_z = 1'b0, m_c = 1'b0, m_p = 1'b0;
    rec_t        sched[$];
    logic [15:0] imem [64];
    int          n_vec = 0, n_err = 0, cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expand a fetched instruction into its DECODE / EXEC / WB cycles.
    task automatic build_schedule();
        int   o = int'(m_ir[15:11]);
        int   n;
        rec_t r;
        r = '0; r.busy = 1'b1;
        if (o == 31) begin
            r.act = A_HALT;
            sched.push_back(r);
            return;
        end
        sched.push_back(r);
        n = (o == 3 || o == 4) ? LAT : 1;
        for (int i = 0; i < n; i++) begin
            r = '0; r.busy = 1'b1; r.ex = 1'b1;
            r.act = (i == n - 1) ? A_FLAGS : A_NONE;
            sched.push_back(r);
        end
        r = '0; r.busy = 1'b1; r.act = A_WB;
        r.rwe  = (o <= 11) || (o >= 16 && o <= 21);
        r.wide = (o == 3) || (o == 4);
        r.mwe  = (o == 12);
        sched.push_back(r);
    endtask

    task automatic model_step();
        rec_t e;
        int   o = int'(m_ir[15:11]);
        logic take;
        if (reset) begin
            m_mode = M_IDLE; m_pause = 1'b0; m_pc = PCR; m_ir = 16'h0000;
            m_z = 1'b0; m_c = 1'b0; m_p = 1'b0;
            sched.delete();
            return;
        end
        case (m_mode)
            M_IDLE: if (start) m_mode = M_RUN;
            M_HALT: ;
            default: begin
                if (sched.size() != 0) begin
                    e = sched.pop_front();
                    if (e.act == A_FLAGS) begin
                        if ((o >= 1 && o <= 10) || (o >= 16 && o <= 21) || o == 25) begin
                            m_z = zero_in; m_p = parity_in;
                        end
                        if (o == 1 || o == 2 || o == 5 || o == 6 || (o >= 16 && o <= 19))
                            m_c = carry_in;
                    end else if (e.act == A_WB) begin
                        take = (o == 13) || (o == 14 && m_z) || (o == 22 && m_c) ||
                               (o == 23 && m_p) || (o == 24 && !m_z);
                        if (take) m_pc = m_ir[5:0];
                        m_pause = (PW != 0);
                    end else if (e.act == A_HALT) begin
                        m_mode = M_HALT;
                    end
                end else if (m_pause) begin
`ifdef EXEC_SEQ_SINGLE_STEP_EN
                    if (step) m_pause = 1'b0;
`endif
                end else if (instr_valid) begin
                    m_ir = instr_data;
                    m_pc = m_pc + 6'd1;
                    build_schedule();
                end
            end
        endcase
    endtask

    function automatic rec_t cur_exp();
        rec_t r;
        r = '0;
        if (m_mode == M_RUN) begin
            if (sched.size() != 0) r = sched[0];
            else if (m_pause)      r.busy = 1'b1;
            else begin r.req = 1'b1; r.busy = 1'b1; end
        end else if (m_mode == M_HALT) begin
            r.halted = 1'b1;
        end
        return r;
    endfunction

    task automatic compare();
        rec_t x = cur_exp();
        check("instr_req",   32'(instr_req),   32'(x.req));
        check("exec_enable", 32'(exec_enable), 32'(x.ex));
        check("reg_we",      32'(reg_we),      32'(x.rwe));
        check("reg_we_wide", 32'(reg_we_wide), 32'(x.wide));
        check("mem_we",      32'(mem_we),      32'(x.mwe));
        check("busy",        32'(busy),        32'(x.busy));
        check("halted",      32'(halted),      32'(x.halted));
        check("pc",          32'(pc),          32'(m_pc));
        check("instr_addr",  32'(instr_addr),  32'(m_pc));
        check("z_flag",      32'(z_flag),      32'(m_z));
        check("c_flag",      32'(c_flag),      32'(m_c));
        check("p_flag",      32'(p_flag),      32'(m_p));
        check("opcode",      32'(opcode),      32'(m_ir[15:11]));
        check("am",          32'(am),          32'(m_ir[10]));
        check("rd",          32'(rd),          32'(m_ir[9:7]));
        check("rs1",         32'(rs1),         32'(m_ir[6:4]));
        check("rs2",         32'(rs2),         32'(m_ir[3:1]));
        check("s_r_amount",  32'(s_r_amount),  32'(m_ir[3:1]));
        check("mem_addr",    32'(mem_addr),    32'(m_ir[3:0]));
    endtask

    // One clock: present data, advance the model on the edge, compare on the falling edge.
    task automatic tick();
        instr_data = imem[m_pc];
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        compare();
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); reset = 1'b0;
    endtask

    task automatic go();   // leave IDLE; returns while observing FETCH cycle 1
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic post_wb();
        repeat (PW) tick();
    endtask

    task automatic fill(input logic [15:0] w);
        for (int a = 0; a < 64; a++) imem[a] = w;
    endtask

    function automatic logic [15:0] rand_word();
        logic [4:0] op = 5'($urandom_range(0, 31));
        if (op == 5'd31 && $urandom_range(0, 7) != 0) op = 5'd0;
        return {op, 11'($urandom)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; instr_valid = 1'b1;
        zero_in = 1'b0; carry_in = 1'b0; parity_in = 1'b0; instr_data = 16'h0000;
`ifdef EXEC_SEQ_SINGLE_STEP_EN
        step = 1'b1;
`endif
        @(negedge clk);

        // add r1 at address 0: reg_we only in cycle 4, pc=1 after WB
        fill(16'h0000); imem[0] = 16'h0880;
        do_reset();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pc", 32'(pc), 32'(PCR));
        go();
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) tick();
            check("add_reg_we", 32'(reg_we), 32'(c == 4));
        end
        post_wb(); tick();
        check("add_pc", 32'(pc), 32'd1);
        check("add_refetch", 32'(instr_req), 32'd1);

        // mul: three EXEC cycles, then reg_we together with reg_we_wide
        fill(16'h0000); imem[0] = 16'h1880;
        do_reset(); go();
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) tick();
            check("mul_exec", 32'(exec_enable), 32'(c >= 3 && c <= 5));
            check("mul_we",   32'(reg_we),      32'(c == 6));
            check("mul_wide", 32'(reg_we_wide), 32'(c == 6));
        end
        post_wb(); tick();
        check("mul_next_fetch", 32'(instr_req), 32'd1);

        // sub with zero_in=1, then branch-if-zero to 5; repeat with zero_in=0
        for (int zv = 1; zv >= 0; zv--) begin
            fill(16'h0000); imem[0] = 16'h1080; imem[1] = 16'h7005;
            zero_in = 1'(zv);
            do_reset(); go();
            repeat (3) tick();
            post_wb();
            repeat (4) tick();
            post_wb(); tick();
            check("bz_pc", 32'(pc), (zv == 1) ? 32'd5 : 32'd2);
            check("bz_z",  32'(z_flag), 32'(zv));
        end
        zero_in = 1'b0;

        // instr_valid delayed 5 cycles, jump to 63, jump at 63 to 42
        fill(16'h0000); imem[0] = 16'h683F; imem[63] = 16'h682A;
        instr_valid = 1'b0;
        do_reset(); go();
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) tick();
            check("wait_req", 32'(instr_req), 32'd1);
            check("wait_pc",  32'(pc), 32'd0);
            check("wait_ir",  32'(opcode), 32'd0);
        end
        instr_valid = 1'b1;
        tick();
        check("jmp_dec_req", 32'(instr_req), 32'd0);
        check("jmp_dec_op",  32'(opcode), 32'd13);
        tick(); tick(); post_wb(); tick();
        check("jmp_pc63", 32'(pc), 32'd63);
        tick();
        check("wrap_fetch_pc", 32'(pc), 32'd0);
        tick(); tick(); post_wb(); tick();
        check("jmp_pc42", 32'(pc), 32'd42);

        // plain instruction at 63 leaves pc at 0
        imem[63] = 16'h0880;
        do_reset(); go();
        repeat (3) tick(); post_wb(); tick();
        check("plain63_pc", 32'(pc), 32'd63);
        repeat (3) tick(); post_wb(); tick();
        check("plain63_next", 32'(pc), 32'd0);

        // halt, then start pulses are ignored
        fill(16'h0000); imem[0] = 16'hF800;
        do_reset(); go();
        tick(); tick();
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_busy",   32'(busy), 32'd0);
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        check("halt_sticky", 32'(halted), 32'd1);
        check("halt_no_req", 32'(instr_req), 32'd0);

        // reset in the middle of mul EXEC
        imem[0] = 16'h1880;
        do_reset(); go();
        tick(); tick();
        check("mid_exec", 32'(exec_enable), 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_pc",   32'(pc), 32'(PCR));
        check("mid_rst_we",   32'(reg_we | reg_we_wide | mem_we | exec_enable), 32'd0);
        tick();
        check("mid_rst_idle", 32'(instr_req | reg_we | reg_we_wide), 32'd0);

`ifdef EXEC_SEQ_SINGLE_STEP_EN
        // single-step: PAUSE holds with step=0 and leaves on step=1
        fill(16'h0000); imem[0] = 16'h0880;
        step = 1'b0;
        do_reset(); go();
        repeat (3) tick();
        for (int c = 0; c < 10; c++) begin
            tick();
            check("pause_busy", 32'(busy), 32'd1);
            check("pause_req",  32'(instr_req), 32'd0);
        end
        step = 1'b1; tick();
        check("step_req", 32'(instr_req), 32'd1);
`endif

        // randomized programs, fetch delays, flags and resets
        for (int seg = 0; seg < 16; seg++) begin
            for (int a = 0; a < 64; a++) imem[a] = rand_word();
            do_reset(); go();
            for (int k = 0; k < 350; k++) begin
                start       = ($urandom_range(0, 3) == 0);
                instr_valid = ($urandom_range(0, 9) < 7);
                zero_in     = 1'($urandom_range(0, 1));
                carry_in    = 1'($urandom_range(0, 1));
                parity_in   = 1'($urandom_range(0, 1));
                reset       = ($urandom_range(0, 399) == 0);
`ifdef EXEC_SEQ_SINGLE_STEP_EN
                step        = ($urandom_range(0, 2) == 0);
`endif
                tick();
            end
            reset = 1'b0; start = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
